fft2d_transpose_buf: RTL and testbench



---
 rtl/fft2d_pkg.sv | 33 +++
 rtl/fft2d_tbuf_bank.sv | 40 ++++
 rtl/fft2d_transpose_buf.sv | 127 ++++++++++++
 tb/tb_fft2d_transpose_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fft2d_pkg.sv
// Shared definitions for the 2D FFT corner-turn buffer: lane/slot bit offsets,
// index widths and the CPB-divides-NCOL elaboration check.
`ifndef FFT2D_PKG_SV
`define FFT2D_PKG_SV

`define FFT2D_CHECK_CPB(ncol, cpb) \
    if (((ncol) % (cpb)) != 0) begin : g_cpb_check \
        $error("fft2d: CPB must divide NCOL"); \
    end

package fft2d_pkg;

    localparam int DATALEN_DFLT = 16;
    localparam int CMPLXLEN     = 2 * DATALEN_DFLT;

    // Counter width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of input lane c (real half; imag follows).
    function automatic int lane_lo(input int c, input int dlen);
        return 2 * c * dlen;
    endfunction

    // Low bit of output slot (m, r): column m of the beat, row r.
    function automatic int slot_lo(input int m, input int r, input int nrow, input int dlen);
        return 2 * (m * nrow + r) * dlen;
    endfunction

endpackage

`endif

// File: rtl/fft2d_tbuf_bank.sv
// One NROW x NCOL complex bank: row-wide write port, CPB-column gather read port.
module fft2d_tbuf_bank
    import fft2d_pkg::*;
#(
    parameter int DATALEN = 16,
    parameter int NCOL    = 8,
    parameter int NROW    = 2,
    parameter int CPB     = 8
) (
    input  logic                                 clk,
    input  logic                                 wr_en,
    input  logic [idx_w(NROW)-1:0]               wr_row,
    input  logic [NCOL*2*DATALEN-1:0]            wr_data,
    input  logic [idx_w(NCOL/CPB)-1:0]           rd_beat,
    output logic [CPB*NROW*2*DATALEN-1:0]        rd_data
);

    localparam int CL = 2 * DATALEN;

    logic [NCOL*CL-1:0] mem_q [NROW];

    // Row storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_row] <= wr_data;
        end
    end

    // Column gather for the selected output beat.
    always_comb begin
        rd_data = '0;
        for (int m = 0; m < CPB; m++) begin
            for (int r = 0; r < NROW; r++) begin
                rd_data[slot_lo(m, r, NROW, DATALEN) +: CL] =
                    mem_q[r][lane_lo(int'(rd_beat) * CPB + m, DATALEN) +: CL];
            end
        end
    end

endmodule

// File: rtl/fft2d_transpose_buf.sv
// Double-buffered corner turn: rows in at NCOL samples per beat, columns out
// at CPB columns per beat, with ping-pong banks and valid/ready on both sides.
module fft2d_transpose_buf
    import fft2d_pkg::*;
#(
    parameter int DATALEN = 16,
    parameter int NCOL    = 8,
    parameter int NROW    = 2,
    parameter int CPB     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [NCOL*2*DATALEN-1:0]     in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [CPB*NROW*2*DATALEN-1:0] out_data,
    output logic                          frame_err
);

    `FFT2D_CHECK_CPB(NCOL, CPB)

    localparam int NBEAT = NCOL / CPB;
    localparam int RW    = idx_w(NROW);
    localparam int BW    = idx_w(NBEAT);
    localparam int OW    = CPB * NROW * 2 * DATALEN;
    localparam logic [RW-1:0] LAST_ROW  = RW'(NROW - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [BW-1:0] rd_beat_q, rd_beat_d;
    logic [1:0]    full_q, full_d;
    logic          frame_err_q, frame_err_d;

    logic          wr_fire, rd_fire, last_row;
    logic [OW-1:0] rd_data0, rd_data1;

    fft2d_tbuf_bank #(.DATALEN(DATALEN), .NCOL(NCOL), .NROW(NROW), .CPB(CPB)) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_fire & ~wr_bank_q),
        .wr_row  (wr_row_q),
        .wr_data (in_data),
        .rd_beat (rd_beat_q),
        .rd_data (rd_data0)
    );

    fft2d_tbuf_bank #(.DATALEN(DATALEN), .NCOL(NCOL), .NROW(NROW), .CPB(CPB)) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_fire & wr_bank_q),
        .wr_row  (wr_row_q),
        .wr_data (in_data),
        .rd_beat (rd_beat_q),
        .rd_data (rd_data1)
    );

    // Handshake outputs; reset forces both sides idle.
    always_comb begin
        in_ready  = ~reset & ~full_q[wr_bank_q];
        out_valid = ~reset & full_q[rd_bank_q];
        out_last  = out_valid & (rd_beat_q == LAST_BEAT);
        wr_fire   = in_valid & in_ready;
        rd_fire   = out_valid & out_ready;
        last_row  = (wr_row_q == LAST_ROW);
        if (!out_valid) begin
            out_data = '0;
        end else if (rd_bank_q) begin
            out_data = rd_data1;
        end else begin
            out_data = rd_data0;
        end
    end

    // Counter, bank-select and full-flag updates; write and read target opposite banks.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_row_d    = wr_row_q;
        rd_bank_d   = rd_bank_q;
        rd_beat_d   = rd_beat_q;
        full_d      = full_q;
        frame_err_d = frame_err_q | (wr_fire & (in_last != last_row));
        if (wr_fire && last_row) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_row_d          = '0;
        end else if (wr_fire) begin
            wr_row_d = wr_row_q + RW'(1);
        end else begin
            wr_row_d = wr_row_q;
        end
        if (rd_fire && out_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_beat_d         = '0;
        end else if (rd_fire) begin
            rd_beat_d = rd_beat_q + BW'(1);
        end else begin
            rd_beat_d = rd_beat_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_row_q    <= '0;
            rd_beat_q   <= '0;
            full_q      <= 2'b00;
            frame_err_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_row_q    <= wr_row_d;
            rd_beat_q   <= rd_beat_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft2d_transpose_buf.sv
// Directed bench: default configuration plus an NROW=4, CPB=2 instance.
module tb_fft2d_transpose_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_ready, in_last, out_valid, out_ready, out_last, frame_err;
    logic [255:0] in_data;
    logic [511:0] out_data;
    logic         in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_last2, frame_err2;
    logic [255:0] in_data2;
    logic [255:0] out_data2;

    int n_cmp = 0;
    int n_err = 0;
    int outs;

    fft2d_transpose_buf u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_data(out_data),
        .frame_err(frame_err)
    );

    fft2d_transpose_buf #(.DATALEN(16), .NCOL(8), .NROW(4), .CPB(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_last(in_last2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2), .out_data(out_data2),
        .frame_err(frame_err2)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample (frame f, row r, column c): real = f<<12 | r<<4 | c, imag = real + 0x100.
    function automatic logic [31:0] word(input int f, input int r, input int c);
        logic [15:0] re;
        re = 16'((f << 12) | (r << 4) | c);
        return {re | 16'h0100, re};
    endfunction

    function automatic logic [255:0] row_vec(input int f, input int r);
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[c*32 +: 32] = word(f, r, c);
        return v;
    endfunction

    function automatic logic [511:0] exp_beat(input int f, input int j, input int nrow, input int cpb);
        logic [511:0] v;
        v = '0;
        for (int m = 0; m < cpb; m++)
            for (int r = 0; r < nrow; r++)
                v[(m*nrow + r)*32 +: 32] = word(f, r, j*cpb + m);
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_last2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, '0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 1'b1);
        check_eq("idle_out_valid", out_valid, 1'b0);
        check_eq("idle_frame_err", frame_err, 1'b0);

        // Single frame, one-cycle latency.
        in_valid = 1'b1; in_data = row_vec(0, 0); in_last = 1'b0;
        @(negedge clk);
        check_eq("t1_no_early_valid", out_valid, 1'b0);
        in_data = row_vec(0, 1); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("t1_out_valid", out_valid, 1'b1);
        check_eq("t1_out_last", out_last, 1'b1);
        check_eq("t1_out_data", out_data, exp_beat(0, 0, 2, 8));
        check_eq("t1_frame_err", frame_err, 1'b0);
        check_eq("t1_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t1_drained", out_valid, 1'b0);

        // Back-to-back streaming of 4 frames.
        outs = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = row_vec(1 + i/2, i%2); in_last = (i%2 == 1);
            check_eq("b2b_in_ready", in_ready, 1'b1);
            @(negedge clk);
            if (out_valid) begin
                check_eq("b2b_data", out_data, exp_beat(1 + outs, 0, 2, 8));
                check_eq("b2b_last", out_last, 1'b1);
                outs++;
            end
        end
        in_valid = 1'b0;
        check_eq("b2b_count", outs, 4);
        @(negedge clk);
        check_eq("b2b_drained", out_valid, 1'b0);

        // Backpressure: both banks fill, then one read reopens the input.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = row_vec(5 + i/2, i%2); in_last = (i%2 == 1);
            check_eq("bp_fill_ready", in_ready, 1'b1);
            @(negedge clk);
        end
        in_data = row_vec(7, 0); in_last = 1'b0;
        check_eq("bp_in_ready_low", in_ready, 1'b0);
        check_eq("bp_out_valid", out_valid, 1'b1);
        check_eq("bp_data", out_data, exp_beat(5, 0, 2, 8));
        @(negedge clk);
        check_eq("bp_stable", out_data, exp_beat(5, 0, 2, 8));
        check_eq("bp_still_low", in_ready, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_reopen", in_ready, 1'b1);
        check_eq("bp_second", out_data, exp_beat(6, 0, 2, 8));
        @(negedge clk);
        in_data = row_vec(7, 1); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_full_again", in_ready, 1'b0);
        check_eq("bp_hold6", out_data, exp_beat(6, 0, 2, 8));
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_third", out_data, exp_beat(7, 0, 2, 8));
        check_eq("bp_third_last", out_last, 1'b1);
        @(negedge clk);
        check_eq("bp_drained", out_valid, 1'b0);

        // in_last on row0 flags frame_err; framing follows the row counter.
        in_valid = 1'b1; in_data = row_vec(8, 0); in_last = 1'b1;
        @(negedge clk);
        check_eq("ferr_set", frame_err, 1'b1);
        check_eq("ferr_no_valid", out_valid, 1'b0);
        in_data = row_vec(8, 1); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("ferr_out_valid", out_valid, 1'b1);
        check_eq("ferr_out_data", out_data, exp_beat(8, 0, 2, 8));
        @(negedge clk);
        @(negedge clk);
        check_eq("ferr_sticky", frame_err, 1'b1);

        // Reset with a full bank and a partial frame pending.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = row_vec(9, 0); in_last = 1'b0;
        @(negedge clk);
        in_data = row_vec(9, 1); in_last = 1'b1;
        @(negedge clk);
        in_data = row_vec(10, 0); in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("mrst_in_ready", in_ready, 1'b0);
        check_eq("mrst_out_valid", out_valid, 1'b0);
        check_eq("mrst_out_last", out_last, 1'b0);
        check_eq("mrst_out_data", out_data, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mrst_frame_err", frame_err, 1'b0);
        check_eq("mrst_empty", out_valid, 1'b0);
        check_eq("mrst_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = row_vec(11, 0); in_last = 1'b0;
        @(negedge clk);
        check_eq("mrst_no_stale", out_valid, 1'b0);
        in_data = row_vec(11, 1); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("mrst_valid", out_valid, 1'b1);
        check_eq("mrst_data", out_data, exp_beat(11, 0, 2, 8));
        out_ready = 1'b1;
        @(negedge clk);

        // NROW=4, CPB=2: four beats per frame.
        for (int r = 0; r < 4; r++) begin
            in_valid2 = 1'b1; in_data2 = row_vec(1, r); in_last2 = (r == 3);
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_eq("c2_valid", out_valid2, 1'b1);
            check_eq("c2_last", out_last2, (j == 3));
            check_eq("c2_data", out_data2, exp_beat(1, j, 4, 2));
            @(negedge clk);
        end
        check_eq("c2_drained", out_valid2, 1'b0);
        check_eq("c2_frame_err", frame_err2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
